// File: rtl/shop_pkg.sv
// Shared types and helpers for the shop checkout block.
// SHOP_CHECKOUT_TAX_EN adds the TAX state to the FSM encoding.
package shop_pkg;

`ifdef SHOP_CHECKOUT_TAX_EN
  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_SCAN  = 3'd1,
    ST_TOTAL = 3'd2,
    ST_DONE  = 3'd3,
    ST_TAX   = 3'd4
  } state_e;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SCAN  = 2'd1,
    ST_TOTAL = 2'd2,
    ST_DONE  = 2'd3
  } state_e;
`endif

  localparam logic [7:0]  ASCII_A        = 8'h41;
  localparam logic [15:0] PREFIX_DEFAULT = 16'h4342;

  // Returns {overflow, sum} with the sum clamped to maxVal.
  function automatic logic [32:0] sat_add(input logic [31:0] a,
                                          input logic [31:0] b,
                                          input logic [31:0] maxVal);
    logic [32:0] sum;
    sum = {1'b0, a} + {1'b0, b};
    if (sum > {1'b0, maxVal}) begin
      return {1'b1, maxVal};
    end
    return {1'b0, sum[31:0]};
  endfunction

  function automatic logic item_valid(input logic [31:0] upper,
                                      input logic [31:0] prefix,
                                      input logic [7:0]  letter,
                                      input logic [31:0] items);
    return (upper == prefix) && (letter >= ASCII_A) &&
           ({24'd0, letter} < ({24'd0, ASCII_A} + items));
  endfunction

endpackage

// File: rtl/shop_price_lut.sv
// Combinational item-code decoder: validates the code and returns its
// price with member discount and double-quantity modifiers applied.
module shop_price_lut
  import shop_pkg::*;
#(
  parameter int unsigned           CHARS      = 3,
  parameter logic [8*CHARS-9:0]    PREFIX     = PREFIX_DEFAULT,
  parameter int unsigned           ITEMS      = 4,
  parameter int unsigned           PRICE_STEP = 5,
  parameter int unsigned           DISC       = 2
) (
  input  logic [8*CHARS-1:0] i_code,
  input  logic [1:0]         i_mode,
  output logic               o_valid,
  output logic [31:0]        o_price
);

  logic [7:0]  letter;
  logic [31:0] basePrice;

  // Price is computed unconditionally and masked when the code is invalid.
  always_comb begin
    letter    = i_code[7:0];
    o_valid   = item_valid(32'(i_code[8*CHARS-1:8]), 32'(PREFIX), letter, 32'(ITEMS));
    basePrice = (32'(letter) - 32'(ASCII_A) + 32'd1) * 32'(PRICE_STEP);
    if (i_mode[0]) begin
      basePrice = (basePrice > 32'(DISC)) ? (basePrice - 32'(DISC)) : 32'd0;
    end
    if (i_mode[1]) begin
      basePrice = basePrice << 1;
    end
    o_price = o_valid ? basePrice : 32'd0;
  end

endmodule

// File: rtl/shop_checkout_v.sv
// Sequential shop checkout: prices a stream of item codes, accumulates a
// saturating cart total and produces a done pulse. Optional SHOP_CHECKOUT_TAX_EN.
module shop_checkout_v
  import shop_pkg::*;
#(
  parameter int unsigned           CHARS      = 3,
  parameter logic [8*CHARS-9:0]    PREFIX     = PREFIX_DEFAULT,
  parameter int unsigned           ITEMS      = 4,
  parameter int unsigned           PRICE_STEP = 5,
  parameter int unsigned           DISC       = 2,
  parameter int unsigned           MAX_ITEMS  = 15,
  parameter int unsigned           TOTAL_W    = 16,
  localparam int unsigned          COUNT_W    = $clog2(MAX_ITEMS + 1)
) (
  input  logic                 i_clk,
  input  logic                 i_rst_n,
  input  logic                 i_valid,
  input  logic [8*CHARS-1:0]   i_code,
  output logic                 o_ready,
  input  logic [1:0]           i_mode,
  input  logic                 i_checkout,
  output logic [TOTAL_W-1:0]   o_total,
  output logic [COUNT_W-1:0]   o_count,
  output logic                 o_done,
  output logic                 o_err,
  output logic                 o_ovf
);

  localparam logic [31:0] TOTAL_MAX = 32'((64'd1 << TOTAL_W) - 64'd1);

  state_e               state_q, state_d;
  logic [TOTAL_W-1:0]   total_q, total_d;
  logic [COUNT_W-1:0]   count_q, count_d;
  logic                 err_q, err_d;
  logic                 ovf_q, ovf_d;
  logic                 ready_q, ready_d;
  logic                 done_q, done_d;

  logic                 lutValid;
  logic [31:0]          lutPrice;
  logic                 accept;
  logic [31:0]          accBase;
  logic [32:0]          addRes;
`ifdef SHOP_CHECKOUT_TAX_EN
  logic [32:0]          taxRes;
`endif

  shop_price_lut #(
    .CHARS      (CHARS),
    .PREFIX     (PREFIX),
    .ITEMS      (ITEMS),
    .PRICE_STEP (PRICE_STEP),
    .DISC       (DISC)
  ) u_price_lut (
    .i_code  (i_code),
    .i_mode  (i_mode),
    .o_valid (lutValid),
    .o_price (lutPrice)
  );

  assign accept = i_valid && ready_q;

  // The first accept of a cart starts from zero, so a held total from the
  // previous checkout never leaks into the new cart.
  always_comb begin
    accBase = (state_q == ST_IDLE) ? 32'd0 : 32'(total_q);
    addRes  = sat_add(accBase, lutPrice, TOTAL_MAX);
`ifdef SHOP_CHECKOUT_TAX_EN
    taxRes  = sat_add(32'(total_q), 32'(total_q >> 3), TOTAL_MAX);
`endif
  end

  always_comb begin
    state_d = state_q;
    total_d = total_q;
    count_d = count_q;
    err_d   = err_q;
    ovf_d   = ovf_q;
    case (state_q)
      ST_IDLE, ST_SCAN: begin
        if (accept) begin
          total_d = TOTAL_W'(addRes[31:0]);
          if (state_q == ST_IDLE) begin
            count_d = COUNT_W'(1);
            err_d   = !lutValid;
            ovf_d   = addRes[32];
            state_d = ST_SCAN;
          end else begin
            count_d = count_q + COUNT_W'(1);
            err_d   = err_q | !lutValid;
            ovf_d   = ovf_q | addRes[32];
          end
        end
        if (i_checkout) begin
          state_d = ST_TOTAL;
        end
      end
`ifdef SHOP_CHECKOUT_TAX_EN
      ST_TOTAL: state_d = ST_TAX;
      ST_TAX: begin
        total_d = TOTAL_W'(taxRes[31:0]);
        ovf_d   = ovf_q | taxRes[32];
        state_d = ST_DONE;
      end
`else
      ST_TOTAL: state_d = ST_DONE;
`endif
      ST_DONE:  state_d = ST_IDLE;
      default:  state_d = ST_IDLE;
    endcase
    // Handshake and done flags are derived from the next state so they are registered.
    ready_d = (state_d == ST_IDLE) ||
              ((state_d == ST_SCAN) && (count_d < COUNT_W'(MAX_ITEMS)));
    done_d  = (state_d == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      state_q <= ST_IDLE;
      total_q <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
      ovf_q   <= 1'b0;
      ready_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      total_q <= total_d;
      count_q <= count_d;
      err_q   <= err_d;
      ovf_q   <= ovf_d;
      ready_q <= ready_d;
      done_q  <= done_d;
    end
  end

  assign o_ready = ready_q;
  assign o_total = total_q;
  assign o_count = count_q;
  assign o_done  = done_q;
  assign o_err   = err_q;
  assign o_ovf   = ovf_q;

endmodule

// File: tb/tb_shop_checkout_v.sv
// Self-checking bench for shop_checkout_v with a checkout scoreboard.
// A second instance with TOTAL_W=8 shares the stimulus to exercise saturation.
module tb_shop_checkout_v;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_valid;
  logic [23:0] i_code;
  logic [1:0]  i_mode;
  logic        i_checkout;

  logic        o_ready, o_done, o_err, o_ovf;
  logic [15:0] o_total;
  logic [3:0]  o_count;
  logic        nReady, nDone, nErr, nOvf;
  logic [7:0]  nTotal;
  logic [3:0]  nCount;

`ifdef SHOP_CHECKOUT_TAX_EN
  localparam int LAT = 3;
`else
  localparam int LAT = 2;
`endif

  always #5 i_clk = ~i_clk;

  shop_checkout_v dut (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_code(i_code),
    .o_ready(o_ready), .i_mode(i_mode), .i_checkout(i_checkout),
    .o_total(o_total), .o_count(o_count), .o_done(o_done),
    .o_err(o_err), .o_ovf(o_ovf)
  );

  shop_checkout_v #(.TOTAL_W(8)) dutNarrow (
    .i_clk(i_clk), .i_rst_n(i_rst_n), .i_valid(i_valid), .i_code(i_code),
    .o_ready(nReady), .i_mode(i_mode), .i_checkout(i_checkout),
    .o_total(nTotal), .o_count(nCount), .o_done(nDone),
    .o_err(nErr), .o_ovf(nOvf)
  );

  typedef struct {
    int total;
    int count;
    bit err;
    bit ovf;
    int totalN;
    bit ovfN;
  } exp_t;

  exp_t sb[$];
  int   checks = 0;
  int   fails  = 0;

  int mTotal, mCount, mTotalN;
  bit mErr, mOvf, mOvfN, cartOpen;

  function automatic int modelPrice(input logic [23:0] code, input logic [1:0] mode);
    int p;
    logic [7:0] letter;
    letter = code[7:0];
    if (code[23:8] != 16'h4342 || letter < 8'h41 || letter > 8'h44) return -1;
    p = (int'(letter) - 64) * 5;
    if (mode[0]) p = (p > 2) ? p - 2 : 0;
    if (mode[1]) p = p * 2;
    return p;
  endfunction

  task automatic modelClear();
    mTotal = 0; mCount = 0; mTotalN = 0;
    mErr = 0; mOvf = 0; mOvfN = 0;
  endtask

  task automatic modelAccept(input logic [23:0] code, input logic [1:0] mode);
    int p;
    p = modelPrice(code, mode);
    if (!cartOpen) begin
      modelClear();
      cartOpen = 1;
    end
    mCount++;
    if (p < 0) begin
      mErr = 1;
    end else begin
      mTotal += p;
      if (mTotal > 65535) begin mTotal = 65535; mOvf = 1; end
      mTotalN += p;
      if (mTotalN > 255) begin mTotalN = 255; mOvfN = 1; end
    end
  endtask

  task automatic pushExpected();
    exp_t e;
`ifdef SHOP_CHECKOUT_TAX_EN
    mTotal += mTotal / 8;
    if (mTotal > 65535) begin mTotal = 65535; mOvf = 1; end
    mTotalN += mTotalN / 8;
    if (mTotalN > 255) begin mTotalN = 255; mOvfN = 1; end
`endif
    e.total = mTotal; e.count = mCount; e.err = mErr; e.ovf = mOvf;
    e.totalN = mTotalN; e.ovfN = mOvfN;
    sb.push_back(e);
    cartOpen = 0;
  endtask

  task automatic waitReady();
    int guard = 0;
    while (o_ready !== 1'b1 && guard < 20) begin
      @(posedge i_clk); #1;
      guard++;
    end
    if (o_ready !== 1'b1) begin
      checks++; fails++;
      $display("[TB] FAIL ready_timeout: got %b expected 1", o_ready);
    end
  endtask

  task automatic applyStimulus(input logic [23:0] code, input logic [1:0] mode, input bit chk);
    waitReady();
    i_valid = 1'b1; i_code = code; i_mode = mode; i_checkout = chk;
    if (o_ready === 1'b1) modelAccept(code, mode);
    if (chk) pushExpected();
    @(posedge i_clk); #1;
    i_valid = 1'b0; i_checkout = 1'b0;
  endtask

  task automatic awaitDone(input string name, input int elapsed);
    int n;
    exp_t e;
    n = elapsed;
    while (o_done !== 1'b1 && n < 10) begin
      @(posedge i_clk); #1;
      n++;
    end
    checks++;
    if (n != LAT) begin
      fails++;
      $display("[TB] FAIL %s_latency: got %0d cycles expected %0d", name, n, LAT);
    end
    if (sb.size() == 0) begin
      checks++; fails++;
      $display("[TB] FAIL %s_scoreboard: got empty queue expected an entry", name);
      return;
    end
    e = sb.pop_front();
    checks++;
    if (o_total !== 16'(e.total)) begin
      fails++; $display("[TB] FAIL %s_total: got %0d expected %0d", name, o_total, e.total);
    end
    checks++;
    if (o_count !== 4'(e.count)) begin
      fails++; $display("[TB] FAIL %s_count: got %0d expected %0d", name, o_count, e.count);
    end
    checks++;
    if (o_err !== e.err || o_ovf !== e.ovf) begin
      fails++; $display("[TB] FAIL %s_flags: got err=%b ovf=%b expected err=%b ovf=%b",
                        name, o_err, o_ovf, e.err, e.ovf);
    end
    checks++;
    if (nTotal !== 8'(e.totalN) || nOvf !== e.ovfN) begin
      fails++; $display("[TB] FAIL %s_narrow: got total=%0d ovf=%b expected total=%0d ovf=%b",
                        name, nTotal, nOvf, e.totalN, e.ovfN);
    end
    @(posedge i_clk); #1;
    checks++;
    if (o_done !== 1'b0 || o_total !== 16'(e.total)) begin
      fails++; $display("[TB] FAIL %s_after_done: got done=%b total=%0d expected done=0 total=%0d",
                        name, o_done, o_total, e.total);
    end
  endtask

  task automatic doCheckout(input string name);
    i_checkout = 1'b1;
    pushExpected();
    @(posedge i_clk); #1;
    i_checkout = 1'b0;
    awaitDone(name, 1);
  endtask

  task automatic test_reset();
    i_rst_n = 1'b0; i_valid = 1'b0; i_code = '0; i_mode = '0; i_checkout = 1'b0;
    cartOpen = 0; modelClear();
    repeat (2) @(posedge i_clk);
    #1;
    checks++;
    if (o_total !== 16'd0 || o_count !== 4'd0) begin
      fails++; $display("[TB] FAIL reset_total_count: got %0d/%0d expected 0/0", o_total, o_count);
    end
    checks++;
    if (o_done !== 1'b0 || o_err !== 1'b0 || o_ovf !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_flags: got done=%b err=%b ovf=%b expected 0", o_done, o_err, o_ovf);
    end
    checks++;
    if (o_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL reset_ready: got %b expected 0", o_ready);
    end
    i_rst_n = 1'b1;
    @(posedge i_clk); #1;
    checks++;
    if (o_ready !== 1'b1) begin
      fails++; $display("[TB] FAIL idle_ready: got %b expected 1", o_ready);
    end
  endtask

  task automatic test_basic();
    logic [23:0] codes [4] = '{24'h434241, 24'h434242, 24'h434243, 24'h434244};
    int expTotal;
    foreach (codes[i]) applyStimulus(codes[i], 2'b00, 1'b0);
    doCheckout("basic");
`ifdef SHOP_CHECKOUT_TAX_EN
    expTotal = 56;
`else
    expTotal = 50;
`endif
    checks++;
    if (o_total !== 16'(expTotal) || o_count !== 4'd4) begin
      fails++; $display("[TB] FAIL basic_literal: got %0d/%0d expected %0d/4", o_total, o_count, expTotal);
    end
  endtask

  task automatic test_modes();
    applyStimulus(24'h434241, 2'b01, 1'b0);
    applyStimulus(24'h434243, 2'b10, 1'b0);
    doCheckout("modes");
  endtask

  task automatic test_invalid();
    applyStimulus(24'h434245, 2'b00, 1'b0);
    checks++;
    if (o_err !== 1'b1) begin
      fails++; $display("[TB] FAIL invalid_err_sticky: got %b expected 1", o_err);
    end
    applyStimulus(24'h414241, 2'b00, 1'b0);
    doCheckout("invalid");
  endtask

  task automatic test_back_to_back();
    int accepts = 0;
    waitReady();
    i_valid = 1'b1; i_code = 24'h434244; i_mode = 2'b00;
    for (int c = 0; c < 20; c++) begin
      if (o_ready === 1'b1) begin
        accepts++;
        modelAccept(i_code, i_mode);
      end
      @(posedge i_clk); #1;
    end
    i_valid = 1'b0;
    checks++;
    if (accepts != 15 || o_ready !== 1'b0) begin
      fails++; $display("[TB] FAIL full_stall: got accepts=%0d ready=%b expected 15/0", accepts, o_ready);
    end
    checks++;
    if (o_count !== 4'd15 || o_total !== 16'd300) begin
      fails++; $display("[TB] FAIL full_state: got %0d/%0d expected 15/300", o_count, o_total);
    end
    doCheckout("full");
  endtask

  task automatic test_overflow();
    for (int k = 0; k < 13; k++) applyStimulus(24'h434244, 2'b00, 1'b0);
    checks++;
    if (nTotal !== 8'd255 || nOvf !== 1'b1 || o_ovf !== 1'b0) begin
      fails++; $display("[TB] FAIL sat_narrow: got total=%0d ovf=%b wide_ovf=%b expected 255/1/0",
                        nTotal, nOvf, o_ovf);
    end
    doCheckout("overflow");
    applyStimulus(24'h434241, 2'b00, 1'b0);
    checks++;
    if (nOvf !== 1'b0 || nTotal !== 8'd5) begin
      fails++; $display("[TB] FAIL ovf_clear: got ovf=%b total=%0d expected 0/5", nOvf, nTotal);
    end
    doCheckout("overflow_next");
  endtask

  task automatic test_reset_mid();
    for (int k = 0; k < 3; k++) applyStimulus(24'h434242, 2'b00, 1'b0);
    checks++;
    if (o_count !== 4'd3) begin
      fails++; $display("[TB] FAIL mid_count: got %0d expected 3", o_count);
    end
    i_rst_n = 1'b0;
    @(posedge i_clk); #1;
    i_rst_n = 1'b1;
    cartOpen = 0; modelClear();
    checks++;
    if (o_total !== 16'd0 || o_count !== 4'd0 || o_ready !== 1'b0 || o_done !== 1'b0 ||
        o_err !== 1'b0 || o_ovf !== 1'b0 || nTotal !== 8'd0) begin
      fails++; $display("[TB] FAIL mid_reset: got total=%0d count=%0d ready=%b expected all 0",
                        o_total, o_count, o_ready);
    end
    applyStimulus(24'h434242, 2'b00, 1'b1);
    awaitDone("simul_checkout", 1);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_modes();
    test_invalid();
    test_back_to_back();
    test_overflow();
    test_reset_mid();
    checks++;
    if (sb.size() != 0) begin
      fails++; $display("[TB] FAIL scoreboard_drain: got %0d entries expected 0", sb.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] simulation time limit reached");
  end

endmodule
